// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_refill_ctrl
//  Purpose  : Miss-handling controller between the 4-way cache and main
//             memory. Stalls the CPU on a cache miss. Writes back a dirty
//             victim if there is one, then fetches the missing word. Installs
//             the word through the substitude/substitude_fin handshake and
//             then releases the stall so the held CPU access retries and hits.
//             Keeps saturating miss and writeback counters and a sticky
//             bus-timeout flag.
//  Ports    : clk, rst (async, active-high)
//             CPU side   : cpu_addr, cpu_rd, cpu_wr -> cpu_stall
//             Cache side : r_miss, w_miss, dirty_bit, wb_data, victim_tag,
//                          substitude_fin -> substitude, substitude_data
//             Memory side: mem_rdata, mem_ack -> mem_req, mem_we, mem_addr,
//                          mem_wdata
//             Status     : miss_cnt, wb_cnt, bus_err
//  Revision : 1.0  initial release
// ============================================================================
module cache_refill_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [29:0]      cpu_addr,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   output logic             cpu_stall,
   input  logic             r_miss,
   input  logic             w_miss,
   input  logic             dirty_bit,
   input  logic [31:0]      wb_data,
   input  logic [19:0]      victim_tag,
   output logic             substitude,
   output logic [31:0]      substitude_data,
   input  logic             substitude_fin,
   output logic             mem_req,
   output logic             mem_we,
   output logic [29:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] wb_cnt,
   output logic             bus_err
);

   localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      WB       = 3'd2,
      FILL     = 3'd3,
      SUBST    = 3'd4,
      WAIT_FIN = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [29:0]       addr_q, addr_d;
   logic [19:0]       vtag_q, vtag_d;
   logic [31:0]       wbdata_q, wbdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [29:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              subst_q, subst_d;
   logic [31:0]       subst_data_q, subst_data_d;   // doubles as the fill buffer
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
   logic              bus_err_q, bus_err_d;

   logic w_any_miss;
   logic w_ack;
   logic w_unused_cpu;

   assign w_any_miss = r_miss | w_miss;
   // An ack only counts while a request is actually outstanding.
   assign w_ack      = mem_ack & mem_req_q;
   // cpu_rd/cpu_wr feed the cache directly; the controller keys off the miss flags.
   assign w_unused_cpu = cpu_rd ^ cpu_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         vtag_q       <= '0;
         wbdata_q     <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         subst_q      <= 1'b0;
         subst_data_q <= '0;
         to_cnt_q     <= '0;
         miss_cnt_q   <= '0;
         wb_cnt_q     <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         vtag_q       <= vtag_d;
         wbdata_q     <= wbdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         subst_q      <= subst_d;
         subst_data_q <= subst_data_d;
         to_cnt_q     <= to_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         wb_cnt_q     <= wb_cnt_d;
         bus_err_q    <= bus_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      vtag_d       = vtag_q;
      wbdata_d     = wbdata_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      subst_d      = 1'b0;
      subst_data_d = subst_data_q;
      to_cnt_d     = to_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      wb_cnt_d     = wb_cnt_q;
      bus_err_d    = bus_err_q;

      case (state_q)
         IDLE: begin
            if (w_any_miss) begin
               state_d = CHECK;
               addr_d  = cpu_addr;
               if (miss_cnt_q != c_cnt_max) miss_cnt_d = miss_cnt_q + c_cnt_one;
            end
         end

         // Victim info is valid from the cache this cycle. The memory outputs
         // are registered, so the first request is set up here straight from
         // the inputs; that keeps mem_req valid on the first WB/FILL cycle.
         CHECK: begin
            vtag_d    = victim_tag;
            wbdata_d  = wb_data;
            to_cnt_d  = '0;
            mem_req_d = 1'b1;
            if (dirty_bit) begin
               state_d     = WB;
               mem_we_d    = 1'b1;
               mem_addr_d  = {victim_tag, addr_q[9:0]};
               mem_wdata_d = wb_data;
            end else begin
               state_d    = FILL;
               mem_we_d   = 1'b0;
               mem_addr_d = addr_q;
            end
         end

         WB: begin
            mem_addr_d  = {vtag_q, addr_q[9:0]};
            mem_wdata_d = wbdata_q;
            if (w_ack) begin
               // The fill request follows on the next cycle without a gap.
               if (wb_cnt_q != c_cnt_max) wb_cnt_d = wb_cnt_q + c_cnt_one;
               state_d    = FILL;
               mem_we_d   = 1'b0;
               mem_addr_d = addr_q;
               to_cnt_d   = '0;
            end else if (to_cnt_q == c_to_last) begin
               bus_err_d = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + c_to_one;
            end
         end

         FILL: begin
            if (w_ack) begin
               subst_data_d = mem_rdata;
               subst_d      = 1'b1;
               mem_req_d    = 1'b0;
               state_d      = SUBST;
            end else if (to_cnt_q == c_to_last) begin
               bus_err_d = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + c_to_one;
            end
         end

         SUBST:    state_d = WAIT_FIN;

         WAIT_FIN: if (substitude_fin) state_d = DONE;

         // One cycle for the cache lookup to settle before the CPU retries.
         DONE:     state_d = IDLE;

         default:  state_d = IDLE;
      endcase
   end

   assign cpu_stall       = (state_q != IDLE) | w_any_miss;
   assign substitude      = subst_q;
   assign substitude_data = subst_data_q;
   assign mem_req         = mem_req_q;
   assign mem_we          = mem_we_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign miss_cnt        = miss_cnt_q;
   assign wb_cnt          = wb_cnt_q;
   assign bus_err         = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_refill_ctrl
//  Purpose  : Self-checking bench for cache_refill_ctrl. Memory transactions
//             and installs are scoreboarded against queues filled when each
//             miss is launched; scenario tasks check timing and status inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_refill_ctrl;
   localparam int TIMEOUT_CYCLES = 8;
   localparam int CNT_W          = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [29:0]       cpu_addr = '0;
   logic              cpu_rd = 1'b0;
   logic              cpu_wr = 1'b0;
   logic              cpu_stall;
   logic              r_miss = 1'b0;
   logic              w_miss = 1'b0;
   logic              dirty_bit = 1'b0;
   logic [31:0]       wb_data = '0;
   logic [19:0]       victim_tag = '0;
   logic              substitude;
   logic [31:0]       substitude_data;
   logic              substitude_fin = 1'b0;
   logic              mem_req;
   logic              mem_we;
   logic [29:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic [CNT_W-1:0]  miss_cnt;
   logic [CNT_W-1:0]  wb_cnt;
   logic              bus_err;

   int checks = 0;
   int errors = 0;

   bit          mem_en    = 1'b1;
   int          ack_lat   = 2;
   int          req_age   = 0;
   logic [31:0] fill_word = '0;

   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } mem_txn_t;

   mem_txn_t    exp_mem[$];
   logic [31:0] exp_sub[$];
   mem_txn_t    mon_e;
   logic [31:0] mon_d;

   cache_refill_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_addr       (cpu_addr),
      .cpu_rd         (cpu_rd),
      .cpu_wr         (cpu_wr),
      .cpu_stall      (cpu_stall),
      .r_miss         (r_miss),
      .w_miss         (w_miss),
      .dirty_bit      (dirty_bit),
      .wb_data        (wb_data),
      .victim_tag     (victim_tag),
      .substitude     (substitude),
      .substitude_data(substitude_data),
      .substitude_fin (substitude_fin),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .miss_cnt       (miss_cnt),
      .wb_cnt         (wb_cnt),
      .bus_err        (bus_err)
   );

   always #5 clk = ~clk;

   // Memory model: acks ack_lat cycles after mem_req rises; rdata is only
   // meaningful on the ack cycle, garbage otherwise.
   always @(negedge clk) begin
      if (rst || !mem_req || mem_ack || !mem_en) begin
         mem_ack   = 1'b0;
         mem_rdata = ~fill_word;
         req_age   = 0;
      end else if (req_age >= ack_lat) begin
         mem_ack   = 1'b1;
         mem_rdata = fill_word;
      end else begin
         req_age = req_age + 1;
      end
   end

   // Scoreboard monitor: every cycle with mem_req must match the head
   // transaction (so it also proves stability), popped on ack; every install
   // pulse pops one expected word.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (mem_req === 1'b1) begin
            checks++;
            if (exp_mem.size() == 0) begin
               errors++;
               $display("FAIL mem_unexpected: got req we=%0b addr=%h, expected no request", mem_we, mem_addr);
            end else begin
               mon_e = exp_mem[0];
               if (mem_we !== mon_e.we || mem_addr !== mon_e.addr ||
                   (mon_e.we && mem_wdata !== mon_e.wdata)) begin
                  errors++;
                  $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                           mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.wdata);
               end
               if (mem_ack) void'(exp_mem.pop_front());
            end
         end
         if (substitude === 1'b1) begin
            checks++;
            if (exp_sub.size() == 0) begin
               errors++;
               $display("FAIL subst_unexpected: got install data=%h, expected none", substitude_data);
            end else begin
               mon_d = exp_sub.pop_front();
               if (substitude_data !== mon_d) begin
                  errors++;
                  $display("FAIL subst_data: got %h, expected %h", substitude_data, mon_d);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      r_miss = 1'b0; w_miss = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
      substitude_fin = 1'b0; dirty_bit = 1'b0; mem_en = 1'b1; ack_lat = 2;
      exp_mem.delete(); exp_sub.delete();
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // Launches one miss, plays the cache side and finishes the install.
   task automatic run_miss(input bit is_wr, input logic [29:0] a, input bit dirty,
                           input logic [19:0] vtag, input logic [31:0] wbd,
                           input logic [31:0] rdata);
      int n;
      if (dirty) exp_mem.push_back('{we: 1'b1, addr: {vtag, a[9:0]}, wdata: wbd});
      exp_mem.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
      exp_sub.push_back(rdata);
      fill_word = rdata;
      cpu_addr = a; cpu_rd = !is_wr; cpu_wr = is_wr;
      if (is_wr) w_miss = 1'b1; else r_miss = 1'b1;
      tick();
      w_miss = 1'b0; dirty_bit = dirty; victim_tag = vtag; wb_data = wbd;
      n = 0;
      while (substitude !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 64) begin
         errors++;
         $display("FAIL subst_wait: no install after %0d cycles, expected within 64", n);
      end
      tick();
      checks++;
      if (substitude !== 1'b0) begin
         errors++;
         $display("FAIL subst_pulse: got substitude=%b one cycle later, expected 0", substitude);
      end
      substitude_fin = 1'b1; r_miss = 1'b0; dirty_bit = 1'b0;
      tick();
      substitude_fin = 1'b0;
      checks++;
      if (cpu_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_done: got cpu_stall=%b in DONE, expected 1", cpu_stall);
      end
      tick();
      checks++;
      if (cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got cpu_stall=%b, expected 0", cpu_stall);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({cpu_stall, mem_req, mem_we, substitude, bus_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got stall/req/we/subst/err=%b, expected 00000",
                  {cpu_stall, mem_req, mem_we, substitude, bus_err});
      end
      checks++;
      if (mem_addr !== 30'h0 || mem_wdata !== 32'h0 || substitude_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h sdata=%h, expected zeros",
                  mem_addr, mem_wdata, substitude_data);
      end
      checks++;
      if (miss_cnt !== 2'd0 || wb_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_cnt: got miss=%0d wb=%0d, expected 0/0", miss_cnt, wb_cnt);
      end
   endtask

   task automatic test_clean_read();
      do_reset();
      ack_lat = 2;
      fill_word = 32'hDEADBEEF;
      exp_mem.push_back('{we: 1'b0, addr: 30'h0000_1004, wdata: 32'h0});
      exp_sub.push_back(32'hDEADBEEF);
      cpu_addr = 30'h0000_1004; cpu_rd = 1'b1; r_miss = 1'b1;   // t0
      #1;
      checks++;
      if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL clean_t0: got stall=%b req=%b, expected 1/0", cpu_stall, mem_req);
      end
      tick();                                                       // t1 CHECK
      dirty_bit = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || miss_cnt !== 2'd1) begin
         errors++;
         $display("FAIL clean_t1: got req=%b miss_cnt=%0d, expected 0/1", mem_req, miss_cnt);
      end
      for (int t = 2; t <= 4; t++) begin                            // t2..t4 FILL
         tick();
         checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h0000_1004) begin
            errors++;
            $display("FAIL clean_fill_t%0d: got req=%b we=%b addr=%h, expected 1/0/00001004",
                     t, mem_req, mem_we, mem_addr);
         end
      end
      tick();                                                       // t5 SUBST
      checks++;
      if (substitude !== 1'b1 || substitude_data !== 32'hDEADBEEF || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL clean_t5: got subst=%b data=%h req=%b, expected 1/deadbeef/0",
                  substitude, substitude_data, mem_req);
      end
      tick();                                                       // t6 WAIT_FIN
      checks++;
      if (substitude !== 1'b0 || substitude_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL clean_t6: got subst=%b data=%h, expected 0/deadbeef", substitude, substitude_data);
      end
      substitude_fin = 1'b1; r_miss = 1'b0;
      tick();                                                       // t7 DONE
      substitude_fin = 1'b0;
      checks++;
      if (cpu_stall !== 1'b1) begin
         errors++;
         $display("FAIL clean_t7: got cpu_stall=%b, expected 1", cpu_stall);
      end
      tick();                                                       // t8 IDLE
      checks++;
      if (cpu_stall !== 1'b0 || miss_cnt !== 2'd1 || wb_cnt !== 2'd0) begin
         errors++;
         $display("FAIL clean_t8: got stall=%b miss=%0d wb=%0d, expected 0/1/0", cpu_stall, miss_cnt, wb_cnt);
      end
      cpu_rd = 1'b0;
   endtask

   task automatic test_dirty_read();
      do_reset();
      ack_lat = 1;
      run_miss(1'b0, 30'h0001_2004, 1'b1, 20'hABCDE, 32'h12345678, 32'hCAFEF00D);
      cpu_rd = 1'b0;
      checks++;
      if (wb_cnt !== 2'd1 || miss_cnt !== 2'd1) begin
         errors++;
         $display("FAIL dirty_cnt: got wb=%0d miss=%0d, expected 1/1", wb_cnt, miss_cnt);
      end
   endtask

   task automatic test_write_miss();
      do_reset();
      ack_lat = 3;
      run_miss(1'b1, 30'h0002_0310, 1'b0, 20'h0, 32'h0, 32'hA5A55A5A);
      // The held write retries now and hits; no second miss is counted.
      tick();
      checks++;
      if (cpu_stall !== 1'b0 || miss_cnt !== 2'd1 || wb_cnt !== 2'd0) begin
         errors++;
         $display("FAIL write_retry: got stall=%b miss=%0d wb=%0d, expected 0/1/0", cpu_stall, miss_cnt, wb_cnt);
      end
      cpu_wr = 1'b0;
   endtask

   task automatic test_timeout();
      int n_high;
      do_reset();
      mem_en = 1'b0;
      fill_word = 32'h11112222;
      exp_mem.push_back('{we: 1'b0, addr: 30'h0000_0040, wdata: 32'h0});
      exp_sub.push_back(32'h11112222);
      cpu_addr = 30'h0000_0040; cpu_rd = 1'b1; r_miss = 1'b1;
      tick();
      dirty_bit = 1'b0;
      n_high = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (mem_req === 1'b1) n_high++;
         else if (n_high > 0) break;
      end
      r_miss = 1'b0;
      #1;
      checks++;
      if (n_high != TIMEOUT_CYCLES) begin
         errors++;
         $display("FAIL timeout_len: got mem_req high %0d cycles, expected %0d", n_high, TIMEOUT_CYCLES);
      end
      checks++;
      if (cpu_stall !== 1'b0 || bus_err !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort: got stall=%b err=%b req=%b, expected 0/1/0", cpu_stall, bus_err, mem_req);
      end
      tick(); tick(); tick();
      checks++;
      if (bus_err !== 1'b1 || miss_cnt !== 2'd1 || cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL timeout_sticky: got err=%b miss=%0d stall=%b, expected 1/1/0", bus_err, miss_cnt, cpu_stall);
      end
      checks++;
      if (exp_mem.size() != 1 || exp_sub.size() != 1) begin
         errors++;
         $display("FAIL timeout_noinstall: got pending mem=%0d sub=%0d, expected 1/1", exp_mem.size(), exp_sub.size());
      end
      exp_mem.delete(); exp_sub.delete();
      cpu_rd = 1'b0; mem_en = 1'b1;
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      mem_en = 1'b0;
      exp_mem.push_back('{we: 1'b0, addr: 30'h0000_0888, wdata: 32'h0});
      cpu_addr = 30'h0000_0888; cpu_rd = 1'b1; r_miss = 1'b1;
      tick();
      dirty_bit = 1'b0;
      tick(); tick();
      checks++;
      if (mem_req !== 1'b1 || miss_cnt !== 2'd1) begin
         errors++;
         $display("FAIL midfill_pre: got req=%b miss=%0d, expected 1/1", mem_req, miss_cnt);
      end
      rst = 1'b1; r_miss = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || substitude !== 1'b0) begin
         errors++;
         $display("FAIL midfill_async: got req=%b stall=%b subst=%b, expected 0/0/0", mem_req, cpu_stall, substitude);
      end
      checks++;
      if (miss_cnt !== 2'd0 || wb_cnt !== 2'd0 || bus_err !== 1'b0) begin
         errors++;
         $display("FAIL midfill_cnt: got miss=%0d wb=%0d err=%b, expected 0/0/0", miss_cnt, wb_cnt, bus_err);
      end
      exp_mem.delete(); exp_sub.delete();
      cpu_rd = 1'b0; mem_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      logic [29:0] a;
      int          exp_cnt;
      do_reset();
      ack_lat = 0;
      for (int i = 0; i < 5; i++) begin
         a = 30'h0000_2000 + 30'(i * 64);
         run_miss(1'b0, a, 1'b0, 20'h0, 32'h0, 32'h5000_0000 + 32'(i));
         cpu_rd = 1'b0;
         exp_cnt = (i + 1 > 3) ? 3 : i + 1;
         checks++;
         if (miss_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL sat_miss%0d: got miss_cnt=%0d, expected %0d", i, miss_cnt, exp_cnt);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clean_read();
      test_dirty_read();
      test_write_miss();
      test_timeout();
      test_reset_mid_fill();
      test_saturation();
      tick();
      checks++;
      if (exp_mem.size() != 0 || exp_sub.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got pending mem=%0d sub=%0d, expected 0/0", exp_mem.size(), exp_sub.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
